// File: rtl/alu_param_secure_pkg.sv
// Shared types for the width-parametrised secure ALU: opcodes, FSM states, flag bundle.
package alu_param_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_NOT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic negative;
  } alu_flags_t;

  localparam int OP_NUM = 8;

  // Shift amount field width; a 1-bit field keeps degenerate widths legal.
  function automatic int shamt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/alu_param_secure_if.sv
// Request/response bus of the secure ALU: input handshake, output handshake and status.
interface alu_param_if
  import alu_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             overflow;
  logic             negative;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic             fault;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, zero, overflow, negative,
           busy, op_count, fault
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, zero, overflow, negative,
           busy, op_count, fault
  );
endinterface

// File: rtl/alu_param_secure_core.sv
// Combinational ALU datapath: result plus carry/zero/overflow/negative for one operand pair.
module alu_param_core
  import alu_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             negative_o
);
  localparam int SH_W = shamt_width(WIDTH);

  logic [SH_W-1:0] sh;
  logic [WIDTH:0]  add_w;
  logic [WIDTH:0]  sub_w;
  logic [WIDTH:0]  shl_w;
  logic [WIDTH:0]  shr_w;

  assign sh = b_i[SH_W-1:0];

  // One extra bit on each side captures carry, borrow and the last bit shifted out.
  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} - {1'b0, b_i};
  assign shl_w = {1'b0, a_i} << sh;
  assign shr_w = {a_i, 1'b0} >> sh;

  always_comb begin
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        result_o   = add_w[WIDTH-1:0];
        carry_o    = add_w[WIDTH];
        overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o   = sub_w[WIDTH-1:0];
        carry_o    = sub_w[WIDTH];
        overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_SHL: begin
        result_o = shl_w[WIDTH-1:0];
        carry_o  = shl_w[WIDTH];
      end
      OP_SHR: begin
        result_o = shr_w[WIDTH:1];
        carry_o  = shr_w[0];
      end
      OP_NOT: result_o = ~a_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o     = (result_o == '0);
  assign negative_o = result_o[WIDTH-1];

endmodule

// File: rtl/alu_param_secure.sv
// Multi-cycle secure ALU (IDLE->EXEC->WB) with handshakes and a completed-op counter.
// Defining ALU_LOCKSTEP_EN adds a shadow core whose mismatch raises a sticky fault.
module alu_param_secure
  import alu_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_param_if.slave  bus
);
  state_e           state_q, state_d;
  logic             in_ready, out_valid, busy;
  logic             accept, exec_en, done;

  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;

  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic [CNT_W-1:0] op_count_q;

  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    exec_en   = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec_en = 1'b1;
        state_d = WB;
      end
      WB: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latches only matter once an accept has loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
  end

  alu_param_core #(.WIDTH(WIDTH)) u_core (
    .a_i        (a_q),
    .b_i        (b_q),
    .op_i       (op_q),
    .result_o   (core_res),
    .carry_o    (core_flags.carry),
    .zero_o     (core_flags.zero),
    .overflow_o (core_flags.overflow),
    .negative_o (core_flags.negative)
  );

  // Results persist through WB and the following IDLE until the next EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (exec_en) begin
      result_q <= core_res;
      flags_q  <= core_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    op_count_q <= '0;
    else if (done) op_count_q <= op_count_q + 1'b1;
  end

`ifdef ALU_LOCKSTEP_EN
  logic [WIDTH-1:0] shadow_res;
  alu_flags_t       shadow_flags;
  logic             mismatch;
  logic             fault_q;

  alu_param_core #(.WIDTH(WIDTH)) u_shadow (
    .a_i        (a_q),
    .b_i        (b_q),
    .op_i       (op_q),
    .result_o   (shadow_res),
    .carry_o    (shadow_flags.carry),
    .zero_o     (shadow_flags.zero),
    .overflow_o (shadow_flags.overflow),
    .negative_o (shadow_flags.negative)
  );

  assign mismatch = ({core_res, core_flags} != {shadow_res, shadow_flags});

  always_ff @(posedge clk) begin
    if (!rst_n)                   fault_q <= 1'b0;
    else if (exec_en && mismatch) fault_q <= 1'b1;
  end

  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.result    = result_q;
  assign bus.carry     = flags_q.carry;
  assign bus.zero      = flags_q.zero;
  assign bus.overflow  = flags_q.overflow;
  assign bus.negative  = flags_q.negative;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_param_secure.sv
// Self-checking bench for alu_param_secure: directed vectors, random ops against a
// behavioural model, backpressure, mid-op reset and counter wrap on a narrow-counter instance.
module tb_alu_param_secure;
  import alu_param_pkg::*;

  localparam int W    = 8;
  localparam int CW   = 16;
  localparam int CW_S = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_param_if #(.WIDTH(W), .CNT_W(CW))   bus   ();
  alu_param_if #(.WIDTH(W), .CNT_W(CW_S)) bus_s ();

  alu_param_secure #(.WIDTH(W), .CNT_W(CW))   dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_param_secure #(.WIDTH(W), .CNT_W(CW_S)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  int n_tests = 0;
  int n_fail  = 0;
  int exp_count = 0;

  // Reference: {result, carry, zero, overflow, negative} from plain integer arithmetic.
  function automatic logic [W+3:0] ref_alu(int a, int b, int op);
    int mask = (1 << W) - 1;
    int half = 1 << (W - 1);
    int sh   = b % W;
    int sa   = (a >= half) ? a - (1 << W) : a;
    int sb   = (b >= half) ? b - (1 << W) : b;
    int r = 0, c = 0, v = 0, s;
    case (op)
      0: begin s = a + b; r = s & mask; c = (s > mask); s = sa + sb; v = (s >= half) || (s < -half); end
      1: begin r = (a - b) & mask; c = (a < b); s = sa - sb; v = (s >= half) || (s < -half); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << sh) & mask; c = (sh == 0) ? 0 : (a >> (W - sh)) & 1; end
      6: begin r = a >> sh; c = (sh == 0) ? 0 : (a >> (sh - 1)) & 1; end
      default: r = (~a) & mask;
    endcase
    return {r[W-1:0], c[0], (r == 0), v[0], (r >= half)};
  endfunction

  function automatic logic [W+3:0] obs_main();
    return {bus.result, bus.carry, bus.zero, bus.overflow, bus.negative};
  endfunction

  function automatic logic [2:0] ctrl_main();
    return {bus.out_valid, bus.in_ready, bus.busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one edge; returns with the DUT in EXEC.
  task automatic start_op(int a, int b, int op);
    bus.in_valid = 1'b1;
    bus.a  = a[W-1:0];
    bus.b  = b[W-1:0];
    bus.op = op_e'(op[2:0]);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    if ({obs_main(), bus.op_count, bus.fault, ctrl_main()} !== {{(W+4){1'b0}}, {CW{1'b0}}, 1'b0, 3'b010}) begin
      n_fail++;
      $display("FAIL reset_state: got res=%h flags=%b cnt=%0d fault=%b ctrl=%b, want all 0 with ctrl=010",
               bus.result, obs_main() & 4'hF, bus.op_count, bus.fault, ctrl_main());
    end
    n_tests++;
  endtask

  task automatic test_directed();
    int va[10]  = '{'hFF, 'h7F, 'h00, 'h81, 'h81, 'h5A, 'h0F, 'h80, 'h18, 'hF0};
    int vb[10]  = '{'h01, 'h01, 'h01, 'h01, 'h00, 'h5A, 'h00, 'h01, 'h04, 'h3C};
    int vop[10] = '{0, 0, 1, 5, 6, 4, 7, 1, 5, 2};
    logic [W+3:0] vexp[10] = '{{8'h00, 4'b1100}, {8'h80, 4'b0011}, {8'hFF, 4'b1001},
                               {8'h02, 4'b1000}, {8'h81, 4'b0001}, {8'h00, 4'b0100},
                               {8'hF0, 4'b0001}, {8'h7F, 4'b0010}, {8'h80, 4'b1001},
                               {8'h30, 4'b0000}};
    for (int i = 0; i < 10; i++) begin
      start_op(va[i], vb[i], vop[i]);
      if (ctrl_main() !== 3'b001) begin
        n_fail++;
        $display("FAIL exec_ctrl[%0d]: got ovld/irdy/busy=%b want 001", i, ctrl_main());
      end
      n_tests++;
      tick();
      if (ctrl_main() !== 3'b101) begin
        n_fail++;
        $display("FAIL wb_latency[%0d]: got ovld/irdy/busy=%b want 101", i, ctrl_main());
      end
      if (obs_main() !== vexp[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%0d a=%h b=%h: got res/cznv=%h/%b want %h/%b",
                 i, vop[i], va[i], vb[i], bus.result, obs_main() & 4'hF,
                 vexp[i][W+3:4], vexp[i][3:0]);
      end
      n_tests += 2;
      tick();
      exp_count++;
      if ({bus.op_count, ctrl_main()} !== {exp_count[CW-1:0], 3'b010}) begin
        n_fail++;
        $display("FAIL directed_done[%0d]: got cnt=%0d ctrl=%b want cnt=%0d ctrl=010",
                 i, bus.op_count, ctrl_main(), exp_count);
      end
      n_tests++;
    end
  endtask

  task automatic test_hold_after_wb();
    logic [W+3:0] last;
    last = ref_alu('hF0, 'h3C, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({obs_main(), ctrl_main()} !== {last, 3'b010}) begin
        n_fail++;
        $display("FAIL hold_after_wb[%0d]: got res=%h ctrl=%b want res=%h ctrl=010",
                 i, bus.result, ctrl_main(), last[W+3:4]);
      end
      n_tests++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int a  = int'($urandom_range(0, (1 << W) - 1));
      int b  = int'($urandom_range(0, (1 << W) - 1));
      int op = int'($urandom_range(0, OP_NUM - 1));
      start_op(a, b, op);
      tick();
      if (obs_main() !== ref_alu(a, b, op) || !bus.out_valid) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got res/cznv=%h/%b ovld=%b want %h/%b",
                 i, op, a, b, bus.result, obs_main() & 4'hF, bus.out_valid,
                 ref_alu(a, b, op) >> 4, ref_alu(a, b, op) & 4'hF);
      end
      n_tests++;
      tick();
      exp_count++;
    end
    if ({bus.op_count, bus.fault} !== {exp_count[CW-1:0], 1'b0}) begin
      n_fail++;
      $display("FAIL random_count: got cnt=%0d fault=%b want cnt=%0d fault=0",
               bus.op_count, bus.fault, exp_count);
    end
    n_tests++;
  endtask

  // in_valid stays high throughout; operands change while busy and must be ignored.
  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      int a  = int'($urandom_range(0, (1 << W) - 1));
      int b  = int'($urandom_range(0, (1 << W) - 1));
      int op = int'($urandom_range(0, OP_NUM - 1));
      if (!bus.in_ready) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got in_ready=0 want 1", i);
      end
      n_tests++;
      bus.in_valid = 1'b1;
      bus.a = a[W-1:0];
      bus.b = b[W-1:0];
      bus.op = op_e'(op[2:0]);
      tick();
      bus.a  = ~a[W-1:0];
      bus.b  = W'($urandom);
      bus.op = op_e'(3'(op + 3));
      tick();
      if ({obs_main(), ctrl_main()} !== {ref_alu(a, b, op), 3'b101}) begin
        n_fail++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got res=%h ctrl=%b want res=%h ctrl=101",
                 i, op, a, b, bus.result, ctrl_main(), ref_alu(a, b, op) >> 4);
      end
      n_tests++;
      tick();
      exp_count++;
    end
    bus.in_valid = 1'b0;
    if (bus.op_count !== exp_count[CW-1:0]) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want %0d", bus.op_count, exp_count);
    end
    n_tests++;
  endtask

  task automatic test_backpressure();
    logic [W+3:0] exp_v;
    exp_v = ref_alu('hA5, 'h3C, 1);
    bus.out_ready = 1'b0;
    start_op('hA5, 'h3C, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = W'($urandom);
      tick();
      if ({obs_main(), ctrl_main(), bus.op_count} !== {exp_v, 3'b101, exp_count[CW-1:0]}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got res=%h ctrl=%b cnt=%0d want res=%h ctrl=101 cnt=%0d",
                 i, bus.result, ctrl_main(), bus.op_count, exp_v[W+3:4], exp_count);
      end
      n_tests++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    exp_count++;
    if ({bus.op_count, ctrl_main()} !== {exp_count[CW-1:0], 3'b010}) begin
      n_fail++;
      $display("FAIL backpressure_release: got cnt=%0d ctrl=%b want cnt=%0d ctrl=010",
               bus.op_count, ctrl_main(), exp_count);
    end
    n_tests++;
  endtask

  // k=0 resets during EXEC, k=1 during WB.
  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      start_op('h7F, 'h01, 0);
      if (k == 1) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_count = 0;
      if ({obs_main(), bus.op_count, ctrl_main()} !== {{(W+4){1'b0}}, {CW{1'b0}}, 3'b010}) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got res=%h cnt=%0d ctrl=%b want res=0 cnt=0 ctrl=010",
                 k, bus.result, bus.op_count, ctrl_main());
      end
      n_tests++;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid_pulse[%0d.%0d]: got out_valid=%b want 0", k, i, bus.out_valid);
        end
        n_tests++;
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < (1 << CW_S) + 1; i++) begin
      bus_s.in_valid = 1'b1;
      bus_s.a  = W'(i);
      bus_s.b  = W'(1);
      bus_s.op = OP_ADD;
      tick();
      bus_s.in_valid = 1'b0;
      tick();
      tick();
      if (bus_s.op_count !== CW_S'((i + 1) % (1 << CW_S))) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got cnt=%0d want %0d", i, bus_s.op_count, (i + 1) % (1 << CW_S));
      end
      n_tests++;
    end
  endtask

`ifdef ALU_LOCKSTEP_EN
  task automatic test_lockstep();
    start_op('h12, 'h34, 0);
    force dut.shadow_res = dut.core_res ^ {{(W-1){1'b0}}, 1'b1};
    tick();
    release dut.shadow_res;
    tick();
    start_op('h01, 'h02, 3);
    tick();
    tick();
    if (bus.fault !== 1'b1) begin
      n_fail++;
      $display("FAIL lockstep_sticky: got fault=%b want 1", bus.fault);
    end
    n_tests++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_count = 0;
    if (bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL lockstep_reset: got fault=%b want 0", bus.fault);
    end
    n_tests++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.a           = '0;
    bus.b           = '0;
    bus.op          = OP_ADD;
    bus_s.in_valid  = 1'b0;
    bus_s.out_ready = 1'b1;
    bus_s.a         = '0;
    bus_s.b         = '0;
    bus_s.op        = OP_ADD;
    rst_n = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_directed();
    test_hold_after_wb();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
`ifdef ALU_LOCKSTEP_EN
    test_lockstep();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
